// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: coin codes, debounce states and
// saturating counter helpers.
package vending_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        QUAL = 2'b01,
        HOLD = 2'b10,
        REL  = 2'b11
    } db_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin-sensor channel: 2-flop synchroniser, press/release debounce FSM,
// and a one-cycle o_event strobe marking the edge at which a press qualifies.
module coin_debounce
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_event
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic      r_sync1;
    logic      r_sync2;
    db_state_t r_state;
    logic [7:0] r_cnt;

    // Strobe is valid at the same edge the FSM moves QUAL -> HOLD, so the
    // arbiter can push the coin on that edge.
    assign o_event = (r_state == QUAL) && r_sync2 && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_sync2) begin
                        r_cnt   <= 8'd1;
                        r_state <= QUAL;
                    end
                end
                QUAL: begin
                    if (!r_sync2) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == CNT_LAST) r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!r_sync2) begin
                        r_cnt   <= 8'd1;
                        r_state <= REL;
                    end
                end
                REL: begin
                    if (r_sync2) begin
                        r_state <= HOLD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == CNT_LAST) r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: two debounced sensor channels, arbitration, coin
// FIFO and registered coin/reject outputs. COIN_ACCEPTOR_STATS_EN adds counters.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         nickel_raw,
    input  logic                         dime_raw,
    input  logic                         coin_ready,
    output logic [1:0]                   coin,
    output logic                         coin_return,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
`ifdef COIN_ACCEPTOR_STATS_EN
    ,
    output logic [15:0]                  accepted_cnt,
    output logic [7:0]                   rejected_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] LVL_ONE = {{AW{1'b0}}, 1'b1};

    logic w_nickel_ev;
    logic w_dime_ev;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (nickel_raw),
        .o_event (w_nickel_ev)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (dime_raw),
        .o_event (w_dime_ev)
    );

    logic [1:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] r_level;
    logic [1:0]  r_coin;
    logic        r_return;

    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push_req;
    logic        w_push;
    logic        w_reject;
    logic [1:0]  w_push_code;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A full FIFO still takes a push when the same edge pops the head.
    always_comb begin
        w_pop       = coin_ready && !w_empty;
        w_push_req  = w_nickel_ev ^ w_dime_ev;
        w_push_code = w_nickel_ev ? COIN_5 : COIN_10;
        w_push      = w_push_req && (!w_full || w_pop);
        w_reject    = (w_nickel_ev && w_dime_ev) || (w_push_req && w_full && !w_pop);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_push_code;
        end else begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_mem[r_wr_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_coin   <= COIN_NONE;
            r_return <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + LVL_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + LVL_ONE;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            r_coin   <= w_pop ? r_mem[r_rd_ptr[AW-1:0]] : COIN_NONE;
            r_return <= w_reject;
        end
    end

    assign coin        = r_coin;
    assign coin_return = r_return;
    assign fifo_level  = r_level;

`ifdef COIN_ACCEPTOR_STATS_EN
    logic [15:0] r_accepted;
    logic [7:0]  r_rejected;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_accepted <= 16'd0;
            r_rejected <= 8'd0;
        end else begin
            if (w_push)   r_accepted <= sat_inc16(r_accepted);
            if (w_reject) r_rejected <= sat_inc8(r_rejected);
        end
    end

    assign accepted_cnt = r_accepted;
    assign rejected_cnt = r_rejected;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios with literal
// expectations plus randomized sensor traffic against a run-length model.
module tb_coin_acceptor;

    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       nickel_raw;
    logic       dime_raw;
    logic       coin_ready;
    logic [1:0] coin;
    logic       coin_return;
    logic [2:0] fifo_level;
`ifdef COIN_ACCEPTOR_STATS_EN
    logic [15:0] accepted_cnt;
    logic [7:0]  rejected_cnt;
`endif

    always #5 clk = ~clk;

    coin_acceptor #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .nickel_raw  (nickel_raw),
        .dime_raw    (dime_raw),
        .coin_ready  (coin_ready),
        .coin        (coin),
        .coin_return (coin_return),
        .fifo_level  (fifo_level)
`ifdef COIN_ACCEPTOR_STATS_EN
        ,
        .accepted_cnt(accepted_cnt),
        .rejected_cnt(rejected_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a sensor value reaches the debouncer two edges after it
    // is sampled; a press is a run of D highs while unpressed, a release a run
    // of D lows while pressed.
    int d1[2], d2[2], hi_run[2], lo_run[2];
    bit pressed[2];
    int q[$];
    int e_coin, e_ret, e_acc, e_rej;

    // Observations gathered by the directed scenarios.
    int obs_coins[$];
    int obs_rets, obs_first, obs_steps, obs_max_level;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int raw[2];
        bit ev[2];
        bit pop;
        int head;
        raw[0] = int'(nickel_raw);
        raw[1] = int'(dime_raw);
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                d1[c] = 0; d2[c] = 0; hi_run[c] = 0; lo_run[c] = 0; pressed[c] = 0;
            end
            q.delete();
            e_coin = 0; e_ret = 0; e_acc = 0; e_rej = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                ev[c] = 0;
                if (d2[c] != 0) begin
                    hi_run[c]++; lo_run[c] = 0;
                    if (!pressed[c] && hi_run[c] == D) begin
                        ev[c] = 1; pressed[c] = 1;
                    end
                end else begin
                    lo_run[c]++; hi_run[c] = 0;
                    if (pressed[c] && lo_run[c] == D) pressed[c] = 0;
                end
                d2[c] = d1[c];
                d1[c] = raw[c];
            end
            pop    = coin_ready && (q.size() > 0);
            head   = pop ? q[0] : 0;
            e_ret  = 0;
            if (ev[0] && ev[1]) begin
                e_ret = 1;
            end else if (ev[0] || ev[1]) begin
                if (q.size() < DEPTH || pop) begin
                    q.push_back(ev[0] ? 1 : 2);
                    if (e_acc < 65535) e_acc++;
                end else begin
                    e_ret = 1;
                end
            end
            if (pop) void'(q.pop_front());
            e_coin = head;
            if (e_ret == 1 && e_rej < 255) e_rej++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("coin", int'(coin), e_coin);
        check("coin_return", int'(coin_return), e_ret);
        check("fifo_level", int'(fifo_level), q.size());
`ifdef COIN_ACCEPTOR_STATS_EN
        check("accepted_cnt", int'(accepted_cnt), e_acc);
        check("rejected_cnt", int'(rejected_cnt), e_rej);
`endif
        obs_steps++;
        if (coin != 2'b00) begin
            obs_coins.push_back(int'(coin));
            if (obs_first < 0) obs_first = obs_steps;
        end
        if (coin_return) obs_rets++;
        if (int'(fifo_level) > obs_max_level) obs_max_level = int'(fifo_level);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_obs();
        obs_coins.delete();
        obs_rets = 0; obs_first = -1; obs_steps = 0; obs_max_level = 0;
    endtask

    task automatic insert(input int ch, input int hold);
        if (ch == 0) nickel_raw = 1'b1; else dime_raw = 1'b1;
        run(hold);
        nickel_raw = 1'b0; dime_raw = 1'b0;
        run(D + 4);
    endtask

    initial begin
        int n_hold, d_hold;
        reset = 1'b1; nickel_raw = 1'b0; dime_raw = 1'b0; coin_ready = 1'b0;
        clear_obs();
        @(negedge clk);
        run(3);
        check("reset_coin", int'(coin), 0);
        check("reset_level", int'(fifo_level), 0);
        check("reset_return", int'(coin_return), 0);
        reset = 1'b0;
        run(2);

        // Clean nickel: coin visible 7 cycles after the first raw-high edge.
        coin_ready = 1'b1;
        clear_obs();
        nickel_raw = 1'b1; run(10); nickel_raw = 1'b0; run(D + 4);
        check("nickel_latency", obs_first, 7);
        check("nickel_count", obs_coins.size(), 1);
        check("nickel_code", (obs_coins.size() > 0) ? obs_coins[0] : -1, 1);
        check("nickel_level_end", int'(fifo_level), 0);

        // Bouncy dime.
        clear_obs();
        dime_raw = 1'b1; run(1); dime_raw = 1'b0; run(1);
        dime_raw = 1'b1; run(12);
        dime_raw = 1'b0; run(1); dime_raw = 1'b1; run(1);
        dime_raw = 1'b0; run(1); dime_raw = 1'b1; run(1);
        dime_raw = 1'b0; run(D + 4);
        check("dime_count", obs_coins.size(), 1);
        check("dime_code", (obs_coins.size() > 0) ? obs_coins[0] : -1, 2);
        check("dime_returns", obs_rets, 0);

        // Simultaneous coins are rejected.
        clear_obs();
        nickel_raw = 1'b1; dime_raw = 1'b1; run(8);
        nickel_raw = 1'b0; dime_raw = 1'b0; run(D + 4);
        check("both_coins", obs_coins.size(), 0);
        check("both_returns", obs_rets, 1);

        // Overflow: five nickels while the vending FSM is busy.
        coin_ready = 1'b0;
        clear_obs();
        for (int i = 0; i < 5; i++) insert(0, 6);
        check("full_max_level", obs_max_level, 4);
        check("full_returns", obs_rets, 1);
        check("full_level", int'(fifo_level), 4);
        coin_ready = 1'b1;
        clear_obs();
        run(4);
        check("drain_count", obs_coins.size(), 4);
        check("drain_first", obs_first, 1);
        check("drain_code", (obs_coins.size() > 3) ? obs_coins[3] : -1, 1);
        run(2);
        check("drain_level", int'(fifo_level), 0);

        // FIFO ordering.
        coin_ready = 1'b0;
        insert(1, 6); insert(0, 6); insert(1, 6);
        clear_obs();
        coin_ready = 1'b1;
        run(6);
        check("order_count", obs_coins.size(), 3);
        check("order_0", (obs_coins.size() > 0) ? obs_coins[0] : -1, 2);
        check("order_1", (obs_coins.size() > 1) ? obs_coins[1] : -1, 1);
        check("order_2", (obs_coins.size() > 2) ? obs_coins[2] : -1, 2);

        // Reset discards buffered coins without a return pulse.
        coin_ready = 1'b0;
        insert(0, 6); insert(0, 6);
        check("pre_reset_level", int'(fifo_level), 2);
        clear_obs();
        reset = 1'b1;
        run(1);
        check("post_reset_level", int'(fifo_level), 0);
        check("post_reset_coin", int'(coin), 0);
        check("post_reset_return", obs_rets, 0);
`ifdef COIN_ACCEPTOR_STATS_EN
        check("post_reset_accepted", int'(accepted_cnt), 0);
`endif
        reset = 1'b0;
        run(2);

        // Randomized sensor traffic, readiness and occasional reset.
        n_hold = 0; d_hold = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (n_hold == 0) begin
                nickel_raw = 1'($urandom_range(0, 1));
                n_hold = $urandom_range(1, 10);
            end
            if (d_hold == 0) begin
                dime_raw = 1'($urandom_range(0, 1));
                d_hold = $urandom_range(1, 10);
            end
            n_hold--; d_hold--;
            coin_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end coin acceptor that turns two raw, bouncy coin-sensor lines (nickel, dime) into the clean one-cycle coin codes the vending FSM consumes on its `in` bus: 2'b01 = 5, 2'b10 = 10, 2'b00 = idle. Each sensor is synchronised, debounced and edge-qualified. Accepted coins are buffered in a small FIFO and released only while the vending FSM signals readiness. Coins that cannot be accepted are physically returned via a reject pulse.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required to qualify a press or a release; legal range is 2 to 255.
- FIFO_DEPTH, 4: coin buffer entries; must be a power of 2, minimum 2.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- nickel_raw  in  1  asynchronous nickel sensor; high while a coin is in the slot.
- dime_raw  in  1  asynchronous dime sensor; high while a coin is in the slot.
- coin_ready  in  1  downstream FSM can take a coin this cycle (low while vending).
- coin  out  2  coin code to the vending FSM; 2'b00 when idle; non-zero for exactly one cycle per coin.
- coin_return  out  1  one-cycle pulse that fires the reject flap.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of buffered coins.

## Operation
- Synchroniser: a 2-flop chain runs per raw line. All debounce logic uses only the synchronised signal.
- Per-channel debounce FSM, with an 8-bit counter `cnt`:
  - IDLE: on sync high, set cnt=1 and go to QUAL.
  - QUAL: on sync low, go to IDLE. Otherwise cnt++. When cnt reaches DEBOUNCE_CYCLES, raise a one-cycle `event` and go to HOLD.
  - HOLD: on sync low, set cnt=1 and go to REL.
  - REL: on sync high, go to HOLD. Otherwise cnt++. When cnt reaches DEBOUNCE_CYCLES, go to IDLE.
  - Result: exactly one event per physical coin. Glitches shorter than DEBOUNCE_CYCLES produce nothing.
- Arbitration, evaluated at the same edge as the events:
  - Nickel event only: push 2'b01.
  - Dime event only: push 2'b10.
  - Both events in the same cycle: ambiguous, so push nothing and pulse coin_return once.
  - Push requested while the FIFO is full and no pop happens that cycle: drop the coin and pulse coin_return.
  - Full FIFO with a pop in the same cycle: the push is accepted and the level stays unchanged.
- Output stage: at each edge, if coin_ready=1 and the FIFO is non-empty, register coin <= head and pop. Otherwise coin <= 2'b00.
- No bypass: a coin pushed at edge P cannot be popped before edge P+1.
- Coin order is preserved (FIFO).

## Timing
- Reset values: coin=2'b00, coin_return=0, fifo_level=0, FIFO empty, pointers 0, both channel FSMs in IDLE with cnt=0, synchroniser flops 0.
- Reset asserted mid-operation discards buffered coins, and no coin_return pulse is issued for them.
- A raw line rising before edge E and held steady produces:
  - sync high sampled at E+2;
  - event and push at edge E+1+DEBOUNCE_CYCLES;
  - coin driven non-zero in the cycle after edge E+2+DEBOUNCE_CYCLES, provided coin_ready=1 and the FIFO was empty.
- coin_return is registered and asserts in the cycle after the rejecting edge.
- fifo_level updates at the push/pop edge: +1 for a push, -1 for a pop, 0 for both.
- A coin_ready deassertion takes effect at the next edge. A coin already registered on coin is not recalled.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by the extra pointer MSB.

## Configuration
- COIN_ACCEPTOR_STATS_EN defined: adds two output ports.
  - accepted_cnt out 16: incremented on every push.
  - rejected_cnt out 8: incremented on every coin_return.
  - Both reset to 0 and saturate at all-ones.
- Undefined: the ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package `vending_pkg`:
  - coin code constants: COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10;
  - debounce state typedef: IDLE, QUAL, HOLD, REL.
- Sub-module `coin_debounce`, instantiated twice, contains synchroniser, FSM and counter, and outputs `event`.
- The top level holds arbitration, the FIFO, the output register and the optional stats.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and FIFO_DEPTH=4.
- Clean nickel held 10 cycles with coin_ready=1 -> exactly one cycle of coin=2'b01, 7 cycles after the first raw-high edge; fifo_level returns to 0.
- Dime with 3-cycle bounces at both edges, held 12 cycles -> exactly one coin=2'b10 and no coin_return.
- nickel_raw and dime_raw rise on the same cycle and are held 8 cycles -> coin stays 2'b00 and coin_return pulses once.
- coin_ready=0 while 5 nickels are inserted -> fifo_level reaches 4 and the 5th coin produces coin_return. After coin_ready=1, four cycles of coin=2'b01 follow back to back.
- Interleaved dime, nickel, dime with coin_ready low, then high -> output order 10, 01, 10.
- Reset asserted with fifo_level=2 -> the next cycle shows fifo_level=0 and coin=2'b00. With COIN_ACCEPTOR_STATS_EN, accepted_cnt reads 0.
